// File: rtl/uart_tx_core.sv
// UART transmitter: 8-entry byte FIFO feeding a start/8-data/parity/1-2-stop framer.
// Framing, parity and bit timing are latched per frame when the FIFO head is loaded.
module uart_tx_core #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIV_W-1:0]  baud_divisor,
  input  logic              parity_sel,
  input  logic              two_stop_bits,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              overflow
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int FRAME_W = DATA_W + 4;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [FRAME_W-1:0] frame_sr;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   baud_cnt;
  logic [3:0]         bits_left;
  logic               push, pop, bit_done;

  function automatic logic parity_bit(input logic [DATA_W-1:0] d, input logic even);
    return even ? ^d : ~^d;
  endfunction

  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = wr_en && !fifo_full;
  assign pop        = (state == LOAD);
  assign bit_done   = (baud_cnt == div_q);
  assign tx_busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (bit_done && bits_left == 4'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Data storage: FIFO array, frame shift register and per-frame divisor carry no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
    if (state == LOAD) begin
      frame_sr <= {2'b11, parity_bit(mem[rd_ptr], parity_sel), mem[rd_ptr], 1'b0};
      div_q    <= baud_divisor;
    end else if (state == SHIFT && bit_done) begin
      frame_sr <= frame_sr >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      tx_out    <= 1'b1;
      baud_cnt  <= '0;
      bits_left <= '0;
    end else begin
      // Full is judged on the pre-edge count, so a same-edge pop never rescues a write.
      overflow <= wr_en && fifo_full;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      case (state)
        LOAD: begin
          tx_out    <= 1'b0;
          baud_cnt  <= '0;
          bits_left <= two_stop_bits ? 4'd12 : 4'd11;
        end
        SHIFT: begin
          if (bit_done) begin
            baud_cnt  <= '0;
            bits_left <= bits_left - 4'd1;
            tx_out    <= (bits_left == 4'd1) ? 1'b1 : frame_sr[1];
          end else begin
            baud_cnt <= baud_cnt + DIV_W'(1);
          end
        end
        default: tx_out <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: frames are predicted from byte, parity and stop
// settings and compared bit period by bit period against the serial line.
module tb_uart_tx_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] baud_divisor = '0;
  logic        parity_sel = 1'b1;
  logic        two_stop_bits = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        wr_en = 1'b0;
  logic        tx_out, tx_busy, fifo_full, fifo_empty, overflow;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  uart_tx_core #(.DATA_W(8), .FIFO_DEPTH(8), .DIV_W(12)) dut (
    .clk(clk), .reset(reset), .baud_divisor(baud_divisor), .parity_sel(parity_sel),
    .two_stop_bits(two_stop_bits), .wr_data(wr_data), .wr_en(wr_en), .tx_out(tx_out),
    .tx_busy(tx_busy), .fifo_full(fifo_full), .fifo_empty(fifo_empty), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  // Expected line: start 0, data LSB first, parity (even: total ones even), stop 1s.
  task automatic check_frame(input logic [7:0] d, input int div, input bit even, input bit two,
                             input int budget, input string name,
                             output int start_cyc, output int busy_cnt);
    logic bits [12];
    int   nb, n, ones;
    bit   bad;
    logic got;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i];
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    bits[9]  = even ? logic'(ones % 2) : logic'(1 - ones % 2);
    bits[10] = 1'b1;
    bits[11] = 1'b1;
    nb = two ? 12 : 11;
    busy_cnt = 0;
    n = 0;
    while (tx_out !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (tx_out !== 1'b0) begin
      errors++;
      start_cyc = -1;
      $display("FAIL %s start: tx_out=%b, expected 0 within %0d cycles", name, tx_out, budget);
      return;
    end
    start_cyc = cyc;
    for (int j = 0; j < nb; j++) begin
      bad = 1'b0;
      got = bits[j];
      for (int k = 0; k <= div; k++) begin
        if (tx_out !== bits[j]) begin
          bad = 1'b1;
          got = tx_out;
        end
        if (tx_busy === 1'b1) busy_cnt++;
        tick();
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s bit%0d: tx_out=%b expected %b (byte %h)", name, j, got, bits[j], d);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (tx_out !== 1'b1)     begin errors++; $display("FAIL reset_tx_out: got %b expected 1", tx_out); end
    checks++; if (tx_busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
    checks++; if (fifo_full !== 1'b0)  begin errors++; $display("FAIL reset_full: got %b expected 0", fifo_full); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", fifo_empty); end
    checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    reset = 1'b0;
    tick();
    checks++; if (tx_out !== 1'b1)     begin errors++; $display("FAIL idle_tx_out: got %b expected 1", tx_out); end
  endtask

  task automatic test_basic_frame;
    int c0, s, b;
    baud_divisor = 12'd3; parity_sel = 1'b1; two_stop_bits = 1'b0;
    write_byte(8'hA5);
    c0 = cyc;
    tick();
    checks++;
    if (tx_busy !== 1'b1 || tx_out !== 1'b1) begin
      errors++; $display("FAIL t1_load: busy=%b tx=%b expected busy=1 tx=1", tx_busy, tx_out);
    end
    check_frame(8'hA5, 3, 1'b1, 1'b0, 4, "t1", s, b);
    checks++; if (s - c0 != 2) begin errors++; $display("FAIL t1_latency: got %0d expected 2", s - c0); end
    checks++; if (b + 1 != 45) begin errors++; $display("FAIL t1_busy_len: got %0d expected 45", b + 1); end
    checks++;
    if (tx_busy !== 1'b0 || tx_out !== 1'b1) begin
      errors++; $display("FAIL t1_end: busy=%b tx=%b expected busy=0 tx=1", tx_busy, tx_out);
    end
  endtask

  task automatic test_fast_two_stop;
    int s, b;
    baud_divisor = 12'd0; parity_sel = 1'b0; two_stop_bits = 1'b1;
    write_byte(8'h01);
    check_frame(8'h01, 0, 1'b0, 1'b1, 6, "t2", s, b);
    checks++; if (b != 12) begin errors++; $display("FAIL t2_len: busy cycles %0d expected 12", b); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL t2_idle: busy=%b expected 0", tx_busy); end
  endtask

  task automatic test_overflow;
    int first_full, ovf_cnt, ovf_at, s, b, bad_idle;
    first_full = -1; ovf_cnt = 0; ovf_at = -1;
    baud_divisor = 12'd100; parity_sel = 1'b1; two_stop_bits = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          wr_data = 8'(i);
          wr_en   = 1'b1;
          tick();
          if (fifo_full === 1'b1 && first_full < 0) first_full = i;
          if (overflow === 1'b1) begin ovf_cnt++; ovf_at = i; end
        end
        wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
          tick();
          if (overflow === 1'b1) ovf_cnt++;
        end
      end
      begin
        for (int i = 0; i < 9; i++) check_frame(8'(i), 100, 1'b1, 1'b0, 300, $sformatf("t3_f%0d", i), s, b);
      end
    join
    checks++; if (first_full != 8) begin errors++; $display("FAIL t3_full_at: got %0d expected 8", first_full); end
    checks++; if (ovf_cnt != 1)    begin errors++; $display("FAIL t3_ovf_count: got %0d expected 1", ovf_cnt); end
    checks++; if (ovf_at != 9)     begin errors++; $display("FAIL t3_ovf_at: got %0d expected 9", ovf_at); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL t3_empty: got %b expected 1", fifo_empty); end
    bad_idle = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (tx_out !== 1'b1) bad_idle++;
    end
    checks++; if (bad_idle != 0) begin errors++; $display("FAIL t3_lost_byte: %0d low cycles expected 0", bad_idle); end
  endtask

  task automatic test_reset_mid_frame;
    int n, bad_idle;
    baud_divisor = 12'd7; parity_sel = 1'b1; two_stop_bits = 1'b0;
    write_byte(8'hFF);
    write_byte(8'h3C);
    n = 0;
    while (tx_out !== 1'b0 && n < 10) begin tick(); n++; end
    checks++; if (tx_out !== 1'b0) begin errors++; $display("FAIL t4_start: tx_out=%b expected 0", tx_out); end
    repeat (4 * 8 + 3) tick();
    checks++; if (fifo_empty !== 1'b0) begin errors++; $display("FAIL t4_queued: empty=%b expected 0", fifo_empty); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (tx_out !== 1'b1)     begin errors++; $display("FAIL t4_tx_out: got %b expected 1", tx_out); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL t4_empty: got %b expected 1", fifo_empty); end
    checks++; if (tx_busy !== 1'b0)    begin errors++; $display("FAIL t4_busy: got %b expected 0", tx_busy); end
    bad_idle = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (tx_out !== 1'b1 || tx_busy !== 1'b0) bad_idle++;
    end
    checks++; if (bad_idle != 0) begin errors++; $display("FAIL t4_quiet: %0d active cycles expected 0", bad_idle); end
  endtask

  task automatic test_config_latch;
    int s, b;
    logic [7:0] d1, d2;
    d1 = 8'($urandom_range(0, 255));
    d2 = 8'($urandom_range(0, 255));
    baud_divisor = 12'd3; parity_sel = 1'b1; two_stop_bits = 1'b0;
    write_byte(d1);
    fork
      check_frame(d1, 3, 1'b1, 1'b0, 4, "t5_old", s, b);
      begin
        repeat (15) tick();
        parity_sel = 1'b0; two_stop_bits = 1'b1; baud_divisor = 12'd2;
      end
    join
    checks++; if (b != 44) begin errors++; $display("FAIL t5_old_len: busy cycles %0d expected 44", b); end
    write_byte(d2);
    check_frame(d2, 2, 1'b0, 1'b1, 4, "t5_new", s, b);
    checks++; if (b != 36) begin errors++; $display("FAIL t5_new_len: busy cycles %0d expected 36", b); end
  endtask

  task automatic test_back_to_back;
    int s1, s2, b, e1;
    baud_divisor = 12'd1; parity_sel = 1'b1; two_stop_bits = 1'b0;
    write_byte(8'h5A);
    write_byte(8'hC3);
    check_frame(8'h5A, 1, 1'b1, 1'b0, 4, "t6_a", s1, b);
    e1 = cyc;
    check_frame(8'hC3, 1, 1'b1, 1'b0, 6, "t6_b", s2, b);
    checks++; if (s2 - e1 != 2) begin errors++; $display("FAIL t6_gap: got %0d expected 2", s2 - e1); end
  endtask

  task automatic test_random;
    for (int batch = 0; batch < 4; batch++) begin
      logic [7:0] q[$];
      int div, nbytes, s, b, prev_end;
      bit even, two;
      div = $urandom_range(0, 4);
      even = 1'($urandom_range(0, 1));
      two  = 1'($urandom_range(0, 1));
      nbytes = $urandom_range(2, 8);
      for (int i = 0; i < nbytes; i++) q.push_back(8'($urandom_range(0, 255)));
      baud_divisor = 12'(div); parity_sel = even; two_stop_bits = two;
      prev_end = -1;
      fork
        for (int i = 0; i < nbytes; i++) write_byte(q[i]);
        for (int i = 0; i < nbytes; i++) begin
          check_frame(q[i], div, even, two, 8, $sformatf("rnd%0d_f%0d", batch, i), s, b);
          if (i > 0) begin
            checks++;
            if (s - prev_end != 2) begin
              errors++; $display("FAIL rnd%0d_gap%0d: got %0d expected 2", batch, i, s - prev_end);
            end
          end
          prev_end = cyc;
        end
      join
      checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL rnd%0d_empty: got %b expected 1", batch, fifo_empty); end
      repeat (3) tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_fast_two_stop();
    test_overflow();
    test_reset_mid_frame();
    test_config_latch();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
